// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - raster timing generator (x/y coordinates, hsync/vsync/blank); optional VGA_TIMING_PIXDIV2_EN
module vga_timing #(
    parameter int H_VISIBLE       = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_VISIBLE       = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] x_px,
    output logic [9:0] y_px,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic       line_start,
    output logic       frame_start,
    output logic       pix_ce
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_STOP    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_STOP    = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic        SYNC_ON    = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

`ifdef VGA_TIMING_PIXDIV2_EN
    // Reset to 1 so the first cycle after release is a stepping cycle.
    logic ce_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ce_q <= 1'b1;
        end else begin
            ce_q <= ~ce_q;
        end
    end

    assign pix_ce = ce_q;
`else
    assign pix_ce = 1'b1;
`endif

    logic       x_wrap;
    logic       y_wrap;
    logic [9:0] x_nxt;
    logic [9:0] y_nxt;
    logic       h_act_nxt;
    logic       v_act_nxt;
    logic       blank_nxt;

    // Sync/blank are decoded from the next coordinate so registered outputs
    // line up with the coordinate they describe.
    always_comb begin
        x_wrap    = (x_px == H_LAST);
        y_wrap    = (y_px == V_LAST);
        x_nxt     = x_wrap ? 10'd0 : x_px + 10'd1;
        y_nxt     = y_px;
        if (x_wrap) begin
            y_nxt = y_wrap ? 10'd0 : y_px + 10'd1;
        end
        h_act_nxt = ({1'b0, x_nxt} >= HS_START) && ({1'b0, x_nxt} < HS_STOP);
        v_act_nxt = ({1'b0, y_nxt} >= VS_START) && ({1'b0, y_nxt} < VS_STOP);
        blank_nxt = ({1'b0, x_nxt} >= H_VIS_END) || ({1'b0, y_nxt} >= V_VIS_END);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_px        <= H_LAST;
            y_px        <= V_LAST;
            blank       <= 1'b1;
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_ce) begin
            x_px        <= x_nxt;
            y_px        <= y_nxt;
            blank       <= blank_nxt;
            hsync       <= h_act_nxt ? SYNC_ON : ~SYNC_ON;
            vsync       <= v_act_nxt ? SYNC_ON : ~SYNC_ON;
            line_start  <= (x_nxt == 10'd0);
            frame_start <= (x_nxt == 10'd0) && (y_nxt == 10'd0);
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - scoreboard bench for vga_timing (default and reduced/active-high timing)
module tb_vga_timing;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       bl;
        logic       ls;
        logic       fs;
        logic       ce;
    } obs_t;

`ifdef VGA_TIMING_PIXDIV2_EN
    localparam bit DIV = 1'b1;
`else
    localparam bit DIV = 1'b0;
`endif

    localparam int RUN_A = 4000;
    localparam int RUN_B = 3000;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    logic [9:0] xa, ya, xb, yb;
    logic hsa, vsa, bla, lsa, fsa, cea;
    logic hsb, vsb, blb, lsb, fsb, ceb;

    int total = 0;
    int bad   = 0;
    int hs_line1_a = 0;

    obs_t q_a[$];
    obs_t q_b[$];

    always #5 clk = ~clk;

    vga_timing dut_a (
        .clk(clk), .reset(rst_a), .x_px(xa), .y_px(ya), .hsync(hsa), .vsync(vsa),
        .blank(bla), .line_start(lsa), .frame_start(fsa), .pix_ce(cea)
    );

    vga_timing #(
        .H_VISIBLE(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .SYNC_ACTIVE_LOW(0)
    ) dut_b (
        .clk(clk), .reset(rst_b), .x_px(xb), .y_px(yb), .hsync(hsb), .vsync(vsb),
        .blank(blb), .line_start(lsb), .frame_start(fsb), .pix_ce(ceb)
    );

    // Reference: position is a linear pixel index within the frame.
    function automatic obs_t decode(int p, bit stepped, bit ce,
                                    int hv, int hf, int hsw, int hb,
                                    int vv, int vf, int vsw, bit act_low);
        obs_t e;
        int ht = hv + hf + hsw + hb;
        int x  = p % ht;
        int y  = p / ht;
        bit on = !act_low;
        e.x  = 10'(x);
        e.y  = 10'(y);
        e.hs = (x >= hv + hf && x < hv + hf + hsw) ? on : !on;
        e.vs = (y >= vv + vf && y < vv + vf + vsw) ? on : !on;
        e.bl = (x >= hv) || (y >= vv);
        e.ls = stepped && (x == 0);
        e.fs = stepped && (p == 0);
        e.ce = ce;
        return e;
    endfunction

    task automatic advance(input bit rst, input int tot,
                           inout int p, inout bit stepped, inout bit ce);
        if (rst) begin
            p       = tot - 1;
            stepped = 1'b0;
            ce      = 1'b1;
        end else begin
            stepped = ce;
            if (ce) p = (p + 1) % tot;
            ce = DIV ? !ce : 1'b1;
        end
    endtask

    initial begin : stimulus
        int  pa = 0, pb = 0;
        bit  sa = 0, sb = 0, ca = 1, cb = 1;
        int  rb_left = 0;
        int  ra_at;
        ra_at = 3 + RUN_A + $urandom_range(0, 40);
        for (int cyc = 0; cyc < RUN_A + 100; cyc++) begin
            rst_a = (cyc < 3) || (cyc == ra_at);
            if (cyc < 3) begin
                rst_b = 1'b1;
            end else if (rb_left > 0) begin
                rst_b = 1'b1;
                rb_left--;
            end else if (cyc < RUN_B && $urandom_range(0, 299) == 0) begin
                rst_b   = 1'b1;
                rb_left = $urandom_range(0, 2);
            end else begin
                rst_b = 1'b0;
            end
            advance(rst_a, 800 * 525, pa, sa, ca);
            q_a.push_back(decode(pa, sa, ca, 640, 16, 96, 48, 480, 10, 2, 1'b1));
            advance(rst_b, 32 * 19, pb, sb, cb);
            q_b.push_back(decode(pb, sb, cb, 20, 3, 5, 4, 12, 2, 2, 1'b0));
            @(posedge clk);
            #1;
        end
        repeat (3) @(negedge clk);
        total++;
        if (hs_line1_a != (DIV ? 192 : 96)) begin
            bad++;
            $display("FAIL hsync_width_line1: got %0d cycles want %0d", hs_line1_a, DIV ? 192 : 96);
        end
        total++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got a=%0d b=%0d entries left want 0", q_a.size(), q_b.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : monitor_a
        obs_t e, g;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                g = '{x: xa, y: ya, hs: hsa, vs: vsa, bl: bla, ls: lsa, fs: fsa, ce: cea};
                if (ya == 10'd1 && hsa == 1'b0) hs_line1_a++;
                total++;
                if (g !== e) begin
                    bad++;
                    if (bad < 20)
                        $display("FAIL a_obs @%0t: got x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b ce=%b want x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b ce=%b",
                                 $time, g.x, g.y, g.hs, g.vs, g.bl, g.ls, g.fs, g.ce,
                                 e.x, e.y, e.hs, e.vs, e.bl, e.ls, e.fs, e.ce);
                end
            end
        end
    end

    initial begin : monitor_b
        obs_t e, g;
        forever begin
            @(negedge clk);
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                g = '{x: xb, y: yb, hs: hsb, vs: vsb, bl: blb, ls: lsb, fs: fsb, ce: ceb};
                total++;
                if (g !== e) begin
                    bad++;
                    if (bad < 20)
                        $display("FAIL b_obs @%0t: got x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b ce=%b want x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b ce=%b",
                                 $time, g.x, g.y, g.hs, g.vs, g.bl, g.ls, g.fs, g.ce,
                                 e.x, e.y, e.hs, e.vs, e.bl, e.ls, e.fs, e.ce);
                end
            end
        end
    end

endmodule
